// File: rtl/key_event_decoder.sv
// Key gesture classifier (short/double/long, auto-repeat when KEY_REPEAT_EN is defined); 1 ms timing from an internal prescaler.
// Events are registered one-cycle pulses, double_click 1 cycle after the press; no backpressure, inputs sampled every cycle.
module key_event_decoder #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_press,
    input  logic key_state,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    localparam int CPM = CLK_FREQ / 1000;
    localparam int CW  = (CPM > 1) ? $clog2(CPM) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CPM - 1);
    localparam logic [15:0]   LONG_T   = 16'(LONG_MS);
    localparam logic [15:0]   DOUBLE_T = 16'(DOUBLE_MS);
`ifdef KEY_REPEAT_EN
    localparam logic [15:0]   REP_T    = 16'(REPEAT_MS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [15:0]    ms_q, ms_d, ms_inc;
    logic           ms_tick, clr;
    logic           short_d, double_d, long_d, busy_d;
    logic           short_q, double_q, long_q, busy_q;
`ifdef KEY_REPEAT_EN
    logic           rep_d, rep_q;
`endif

    always_comb begin
        ms_tick  = (cyc_q == CYC_LAST);
        ms_inc   = (ms_q == 16'hFFFF) ? ms_q : ms_q + 16'd1;
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        clr      = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d    = 1'b0;
`endif
        // Thresholds are matched on the tick that would make the ms count
        // reach them, so the event lands exactly N*CPM cycles after entry.
        case (state_q)
            S_IDLE: begin
                if (key_press) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (key_state) begin
                    state_d = S_WAIT2;
                end else if (ms_tick && ms_inc == LONG_T) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_WAIT2: begin
                if (key_press) begin
                    state_d  = S_PRESS2;
                    double_d = 1'b1;
                end else if (ms_tick && ms_inc == DOUBLE_T) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_PRESS2: begin
                if (key_state) state_d = S_IDLE;
            end
            S_LONG: begin
                if (key_state) begin
                    state_d = S_IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (ms_tick && ms_inc == REP_T) begin
                    rep_d = 1'b1;
                    clr   = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) clr = 1'b1;

        if (clr) begin
            cyc_d = '0;
            ms_d  = '0;
        end else if (ms_tick) begin
            cyc_d = '0;
            ms_d  = ms_inc;
        end else begin
            cyc_d = cyc_q + 1'b1;
            ms_d  = ms_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            ms_q     <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            ms_q     <= ms_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= 1'b0;
        else     rep_q <= rep_d;
    end
    assign repeat_tick = rep_q;
`else
    assign repeat_tick = 1'b0;
`endif

    assign short_click  = short_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: timestamp-based gesture model, per-cycle compare, directed and random gestures.
module tb_key_event_decoder;

    localparam int CLK_FREQ  = 10_000;
    localparam int CPM       = 10;
    localparam int LONG_MS   = 50;
    localparam int DOUBLE_MS = 20;
    localparam int REPEAT_MS = 10;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int G_IDLE = 0, G_HELD1 = 1, G_GAP = 2, G_HELD2 = 3, G_HELDLONG = 4;

    logic clk = 1'b0;
    logic rst, key_press, key_state;
    logic short_click, double_click, long_press, repeat_tick, busy;

    always #5 clk = ~clk;

    key_event_decoder #(
        .CLK_FREQ (CLK_FREQ),
        .LONG_MS  (LONG_MS),
        .DOUBLE_MS(DOUBLE_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_press   (key_press),
        .key_state   (key_state),
        .short_click (short_click),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .busy        (busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Gesture model: phase plus timestamp of the last phase entry; events fire
    // when the elapsed edge count hits the ms threshold times CPM.
    int  phase = G_IDLE;
    int  t0 = 0;
    bit  e_short = 0, e_double = 0, e_long = 0, e_rep = 0, e_busy = 0;
    int  m_short_t = -1, m_long_t = -1;

    always @(posedge clk) begin
        cyc++;
        e_short = 0; e_double = 0; e_long = 0; e_rep = 0;
        if (rst) begin
            phase = G_IDLE;
        end else begin
            case (phase)
                G_IDLE: if (key_press) begin phase = G_HELD1; t0 = cyc; end
                G_HELD1:
                    if (key_state) begin phase = G_GAP; t0 = cyc; end
                    else if (cyc - t0 == LONG_MS * CPM) begin
                        e_long = 1; m_long_t = cyc; phase = G_HELDLONG; t0 = cyc;
                    end
                G_GAP:
                    if (key_press) begin e_double = 1; phase = G_HELD2; end
                    else if (cyc - t0 == DOUBLE_MS * CPM) begin
                        e_short = 1; m_short_t = cyc; phase = G_IDLE;
                    end
                G_HELD2: if (key_state) phase = G_IDLE;
                G_HELDLONG:
                    if (key_state) phase = G_IDLE;
                    else if (REP_EN && ((cyc - t0) % (REPEAT_MS * CPM) == 0)) e_rep = 1;
                default: phase = G_IDLE;
            endcase
        end
        e_busy = (phase != G_IDLE);
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("short_click",  short_click,  e_short);
            chk("double_click", double_click, e_double);
            chk("long_press",   long_press,   e_long);
            chk("repeat_tick",  repeat_tick,  e_rep);
            chk("busy",         busy,         e_busy);
        end
    end

    int n_short = 0, n_double = 0, n_long = 0, n_rep = 0;
    int d_short_t = -1, d_double_t = -1, d_long_t = -1;
    int rep_t_q[$];

    always @(negedge clk) begin
        if (short_click)  begin n_short++;  d_short_t  = cyc; end
        if (double_click) begin n_double++; d_double_t = cyc; end
        if (long_press)   begin n_long++;   d_long_t   = cyc; end
        if (repeat_tick)  begin n_rep++;    rep_t_q.push_back(cyc); end
    end

    task automatic clear_counts();
        n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
        d_short_t = -1; d_double_t = -1; d_long_t = -1;
        rep_t_q.delete();
    endtask

    // Returns at the negedge just before posedge number 'target'.
    task automatic at_edge(input int target);
        @(negedge clk);
        while (cyc < target - 1) @(negedge clk);
        if (cyc != target - 1) chk("schedule", cyc, target - 1);
    endtask

    task automatic press_at(input int e);
        at_edge(e);
        key_press = 1'b1;
        key_state = 1'b0;
        @(negedge clk);
        key_press = 1'b0;
    endtask

    task automatic spur_at(input int e);
        at_edge(e);
        key_press = 1'b1;
        @(negedge clk);
        key_press = 1'b0;
    endtask

    task automatic release_at(input int e);
        at_edge(e);
        key_state = 1'b1;
    endtask

    task automatic check_counts(input string tag, input int s, input int d, input int l, input int r);
        chk({tag, " short count"},  n_short,  s);
        chk({tag, " double count"}, n_double, d);
        chk({tag, " long count"},   n_long,   l);
        chk({tag, " repeat count"}, n_rep,    r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p2, r, h, g, rsum;
        rst = 1'b1; key_press = 1'b0; key_state = 1'b1;
        #1;
        chk("reset short",  short_click,  0);
        chk("reset double", double_click, 0);
        chk("reset long",   long_press,   0);
        chk("reset repeat", repeat_tick,  0);
        chk("reset busy",   busy,         0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_chk = 1'b1;

        // Short click: 10 ms hold, 30 ms idle.
        clear_counts();
        p = cyc + 3; r = p + 100;
        press_at(p); release_at(r); at_edge(r + 300);
        check_counts("s1", 1, 0, 0, 0);
        chk("s1 short latency", d_short_t - r, 200);
        chk("s1 model short latency", m_short_t - r, 200);
        chk("s1 busy idle", busy, 0);

        // Double click: 5 ms hold, 10 ms gap.
        clear_counts();
        p = cyc + 3; r = p + 50; p2 = r + 100;
        press_at(p); release_at(r); press_at(p2); release_at(p2 + 20); at_edge(p2 + 320);
        check_counts("s2", 0, 1, 0, 0);
        chk("s2 double latency", d_double_t - (p2 - 1), 1);

        // Long press, 85 ms hold.
        clear_counts();
        p = cyc + 3;
        press_at(p); release_at(p + 850); at_edge(p + 850 + 300);
        check_counts("s3", 0, 0, 1, REP_EN ? 3 : 0);
        chk("s3 long latency", d_long_t - p, 500);
        chk("s3 model long latency", m_long_t - p, 500);
        rsum = 0;
        foreach (rep_t_q[i]) rsum += rep_t_q[i] - p;
        chk("s3 repeat times", rsum, REP_EN ? (600 + 700 + 800) : 0);

        // Release exactly at LONG_MS expiry: release wins.
        clear_counts();
        p = cyc + 3; r = p + 500;
        press_at(p); release_at(r); at_edge(r + 300);
        check_counts("s4a", 1, 0, 0, 0);
        chk("s4a short latency", d_short_t - r, 200);

        // Release one cycle after expiry: long press is taken.
        clear_counts();
        p = cyc + 3;
        press_at(p); release_at(p + 501); at_edge(p + 801);
        check_counts("s4b", 0, 0, 1, 0);

        // Second press at DOUBLE_MS expiry: press wins.
        clear_counts();
        p = cyc + 3; r = p + 100; p2 = r + 200;
        press_at(p); release_at(r); press_at(p2); release_at(p2 + 30); at_edge(p2 + 330);
        check_counts("s4c", 0, 1, 0, 0);

        // Reset 30 ms into a hold.
        clear_counts();
        p = cyc + 3;
        press_at(p); at_edge(p + 300);
        chk("s5 busy before reset", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("s5 rst short",  short_click,  0);
        chk("s5 rst double", double_click, 0);
        chk("s5 rst long",   long_press,   0);
        chk("s5 rst repeat", repeat_tick,  0);
        chk("s5 rst busy",   busy,         0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        release_at(cyc + 100);
        at_edge(cyc + 1000);
        check_counts("s5", 0, 0, 0, 0);
        chk("s5 busy end", busy, 0);

        // Random gestures, with spurious presses while held.
        p = cyc + 3;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       h = 500;
                1:       h = 499;
                default: h = $urandom_range(2, 900);
            endcase
            case ($urandom_range(0, 5))
                0:       g = 200;
                1:       g = 201;
                default: g = $urandom_range(2, 350);
            endcase
            press_at(p);
            if (h >= 10 && $urandom_range(0, 3) == 0) spur_at(p + h / 2);
            release_at(p + h);
            p = p + h + g;
        end
        at_edge(cyc + 400);
        chk("final busy", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
